// File: rtl/glay_kernel_setup_response.sv
// Collects NUM_SETUP_CACHELINE setup cachelines, which may arrive in any order, and presents them as one payload.
// Optional watchdog on the collect phase: define GLAY_SETUP_RSP_TIMEOUT_EN.
module glay_kernel_setup_response #(
   parameter int NUM_SETUP_CACHELINE = 2,
   parameter int CACHELINE_WIDTH     = 512,
   parameter int ADDR_WIDTH          = 64,
   parameter int TIMEOUT_CYCLES      = 4096
) (
   input  logic                                           ap_clk,
   input  logic                                           areset,
   input  logic                                           setup_start,
   input  logic [ADDR_WIDTH-1:0]                          setup_base_addr,
   input  logic                                           rsp_in_valid,
   input  logic [ADDR_WIDTH-1:0]                          rsp_in_addr,
   input  logic [CACHELINE_WIDTH-1:0]                     rsp_in_data,
   output logic                                           rsp_in_ready,
   output logic                                           setup_busy,
   output logic                                           setup_valid,
   output logic [NUM_SETUP_CACHELINE*CACHELINE_WIDTH-1:0] setup_payload,
   output logic                                           setup_error
);

   localparam int LINE_SHIFT = $clog2(CACHELINE_WIDTH / 8);
   localparam int IDX_W      = (NUM_SETUP_CACHELINE > 1) ? $clog2(NUM_SETUP_CACHELINE) : 1;
   localparam int CNT_W      = $clog2(NUM_SETUP_CACHELINE + 1);
   localparam logic [NUM_SETUP_CACHELINE-1:0] MASK_ONE = 1;

   if (NUM_SETUP_CACHELINE < 1 || NUM_SETUP_CACHELINE > 8) begin : g_bad_num
      $error("NUM_SETUP_CACHELINE must be in 1..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be positive");
   end

   typedef enum logic [2:0] {
      ST_RESET,
      ST_IDLE,
      ST_COLLECT,
      ST_STORE,
      ST_DONE
   } state_t;

   state_t                         state;
   state_t                         next_state;
   logic                           reset_q;
   logic [ADDR_WIDTH-1:0]          base_addr;
   logic [NUM_SETUP_CACHELINE-1:0] line_mask;
   logic [CNT_W-1:0]               line_count;
   logic                           rsp_valid_q;
   logic [ADDR_WIDTH-1:0]          rsp_addr_q;
   logic [CACHELINE_WIDTH-1:0]     rsp_data_q;

   logic                           rsp_fire;
   logic                           timeout_hit;
   logic [ADDR_WIDTH-1:0]          cur_offset;
   logic [ADDR_WIDTH-1:0]          cur_line;
   logic [IDX_W-1:0]               cur_idx;
   logic                           cur_good;
   logic                           cur_completes;
   logic [ADDR_WIDTH-1:0]          q_offset;
   logic [ADDR_WIDTH-1:0]          q_line;
   logic [IDX_W-1:0]               q_idx;
   logic                           q_good;
   logic                           q_bad;
   logic [NUM_SETUP_CACHELINE-1:0] pend_mask;
   logic [CNT_W-1:0]               pend_count;

   always_ff @(posedge ap_clk) begin
      reset_q <= areset;
   end

   always_ff @(posedge ap_clk) begin
      if (reset_q) state <= ST_RESET;
      else         state <= next_state;
   end

   always_comb begin
      next_state   = state;
      rsp_in_ready = 1'b0;
      setup_busy   = 1'b0;
      setup_valid  = 1'b0;
      unique case (state)
         ST_RESET: next_state = ST_IDLE;
         ST_IDLE: begin
            if (setup_start) next_state = ST_COLLECT;
         end
         ST_COLLECT: begin
            rsp_in_ready = 1'b1;
            setup_busy   = 1'b1;
            if (cur_completes)    next_state = ST_STORE;
            else if (timeout_hit) next_state = ST_DONE;
         end
         ST_STORE: begin
            setup_busy = 1'b1;
            next_state = ST_DONE;
         end
         ST_DONE: begin
            setup_valid = 1'b1;
            next_state  = ST_IDLE;
         end
         default: next_state = ST_RESET;
      endcase
   end

   // The registered response is checked against the mask; the live response is checked against the mask
   // as it will be once the registered one lands, so completion is known at the handshake itself.
   always_comb begin
      rsp_fire   = rsp_in_valid & rsp_in_ready;

      q_offset   = rsp_addr_q - base_addr;
      q_line     = q_offset >> LINE_SHIFT;
      q_idx      = q_line[IDX_W-1:0];
      q_good     = rsp_valid_q && (q_offset[LINE_SHIFT-1:0] == '0)
                   && (q_line < ADDR_WIDTH'(NUM_SETUP_CACHELINE)) && !line_mask[q_idx];
      q_bad      = rsp_valid_q && !q_good;
      pend_mask  = line_mask | (q_good ? (MASK_ONE << q_idx) : '0);
      pend_count = line_count + CNT_W'(q_good);

      cur_offset = rsp_in_addr - base_addr;
      cur_line   = cur_offset >> LINE_SHIFT;
      cur_idx    = cur_line[IDX_W-1:0];
      cur_good   = rsp_fire && (cur_offset[LINE_SHIFT-1:0] == '0)
                   && (cur_line < ADDR_WIDTH'(NUM_SETUP_CACHELINE)) && !pend_mask[cur_idx];
      cur_completes = cur_good && (pend_count == CNT_W'(NUM_SETUP_CACHELINE - 1));
   end

`ifdef GLAY_SETUP_RSP_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] timeout_cnt;

   always_ff @(posedge ap_clk) begin
      if (reset_q || state != ST_COLLECT || rsp_fire)  timeout_cnt <= '0;
      else if (timeout_cnt != TO_W'(TIMEOUT_CYCLES))   timeout_cnt <= timeout_cnt + TO_W'(1);
   end

   assign timeout_hit = (state == ST_COLLECT) && !rsp_fire && (timeout_cnt == TO_W'(TIMEOUT_CYCLES));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge ap_clk) begin
      if (reset_q) begin
         base_addr     <= '0;
         line_mask     <= '0;
         line_count    <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_addr_q    <= '0;
         rsp_data_q    <= '0;
         setup_payload <= '0;
         setup_error   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_fire;
         if (rsp_fire) begin
            rsp_addr_q <= rsp_in_addr;
            rsp_data_q <= rsp_in_data;
         end
         if (state == ST_IDLE && setup_start) begin
            base_addr     <= setup_base_addr;
            line_mask     <= '0;
            line_count    <= '0;
            setup_payload <= '0;
            setup_error   <= 1'b0;
         end else begin
            if (q_good) begin
               setup_payload[q_idx*CACHELINE_WIDTH +: CACHELINE_WIDTH] <= rsp_data_q;
               line_mask[q_idx] <= 1'b1;
               line_count       <= line_count + CNT_W'(1);
            end
            if (q_bad || timeout_hit) setup_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_glay_kernel_setup_response.sv
// Testbench for glay_kernel_setup_response: directed and randomized collections checked against a line-placement model.
// Define GLAY_SETUP_RSP_TIMEOUT_EN to also exercise the watchdog with a 16-cycle limit.
module tb_glay_kernel_setup_response;

   localparam int N    = 2;
   localparam int CW   = 512;
   localparam int AW   = 64;
   localparam int LINE = CW / 8;
`ifdef GLAY_SETUP_RSP_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 4096;
`endif

   logic            ap_clk;
   logic            areset;
   logic            setup_start;
   logic [AW-1:0]   setup_base_addr;
   logic            rsp_in_valid;
   logic [AW-1:0]   rsp_in_addr;
   logic [CW-1:0]   rsp_in_data;
   logic            rsp_in_ready;
   logic            setup_busy;
   logic            setup_valid;
   logic [N*CW-1:0] setup_payload;
   logic            setup_error;

   int checks      = 0;
   int failures    = 0;
   int validPulses = 0;

   logic [AW-1:0] qAddr[$];
   logic [CW-1:0] qData[$];
   logic [CW-1:0] expLines[N];

   glay_kernel_setup_response #(
      .NUM_SETUP_CACHELINE(N),
      .CACHELINE_WIDTH(CW),
      .ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .ap_clk(ap_clk),
      .areset(areset),
      .setup_start(setup_start),
      .setup_base_addr(setup_base_addr),
      .rsp_in_valid(rsp_in_valid),
      .rsp_in_addr(rsp_in_addr),
      .rsp_in_data(rsp_in_data),
      .rsp_in_ready(rsp_in_ready),
      .setup_busy(setup_busy),
      .setup_valid(setup_valid),
      .setup_payload(setup_payload),
      .setup_error(setup_error)
   );

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   always @(posedge ap_clk) begin
      if (setup_valid === 1'b1) validPulses++;
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge ap_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkPayload(input string tag);
      for (int i = 0; i < N; i++) checkOutput(tag, setup_payload[i*CW +: CW], expLines[i]);
   endtask

   function automatic logic [CW-1:0] randLine();
      logic [CW-1:0] r;
      for (int i = 0; i < CW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Starts a collection at base, feeds qAddr/qData back to back until the model sees every line, then
   // checks the handshake-to-pulse timing, error latency and the final payload.
   task automatic applyStimulus(input logic [AW-1:0] base, input bit dupAfter, input int strayAt);
      bit            seen[N];
      int            nSeen;
      bit            badSoFar;
      bit            thisBad;
      int            pulsesBefore;
      logic [AW-1:0] off;
      longint        lineNo;
      for (int i = 0; i < N; i++) begin
         seen[i]     = 1'b0;
         expLines[i] = '0;
      end
      nSeen    = 0;
      badSoFar = 1'b0;

      setup_start     = 1'b1;
      setup_base_addr = base;
      step();
      setup_start = 1'b0;
      checkOutput("start_ready", CW'(rsp_in_ready), CW'(1));
      checkOutput("start_busy", CW'(setup_busy), CW'(1));
      checkOutput("start_error", CW'(setup_error), CW'(0));
      checkPayload("start_payload_zero");
      pulsesBefore = validPulses;

      for (int k = 0; k < qAddr.size(); k++) begin
         off     = qAddr[k] - base;
         lineNo  = longint'(off / LINE);
         thisBad = (off % LINE != 0) || (off / LINE >= N);
         if (!thisBad && seen[lineNo]) thisBad = 1'b1;
         if (!thisBad) begin
            seen[lineNo]     = 1'b1;
            expLines[lineNo] = qData[k];
            nSeen++;
         end
         rsp_in_valid = 1'b1;
         rsp_in_addr  = qAddr[k];
         rsp_in_data  = qData[k];
         if (k == strayAt) begin
            setup_start     = 1'b1;
            setup_base_addr = base ^ 64'h8000;
         end
         checkOutput("ready_before_hs", CW'(rsp_in_ready), CW'(1));
         step();
         setup_start = 1'b0;
         checkOutput("error_latency", CW'(setup_error), CW'(badSoFar));
         badSoFar = badSoFar | thisBad;
         if (nSeen == N) break;
      end

      if (dupAfter) begin
         rsp_in_valid = 1'b1;
         rsp_in_addr  = base;
         rsp_in_data  = ~expLines[0];
      end else begin
         rsp_in_valid = 1'b0;
      end
      checkOutput("ready_drop", CW'(rsp_in_ready), CW'(0));
      checkOutput("valid_early", CW'(setup_valid), CW'(0));
      checkOutput("busy_store", CW'(setup_busy), CW'(1));
      step();
      rsp_in_valid = 1'b0;
      checkOutput("valid_pulse", CW'(setup_valid), CW'(1));
      checkOutput("error_final", CW'(setup_error), CW'(badSoFar));
      checkOutput("busy_done", CW'(setup_busy), CW'(0));
      checkPayload("payload_done");
      step();
      checkOutput("valid_single", CW'(setup_valid), CW'(0));
      checkOutput("pulse_count", CW'(validPulses - pulsesBefore), CW'(1));
      checkOutput("error_held", CW'(setup_error), CW'(badSoFar));
      checkPayload("payload_held");
   endtask

   task automatic pushBad(input logic [AW-1:0] base, input int line);
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0)      qAddr.push_back(base + AW'(line * LINE) + AW'($urandom_range(1, LINE - 1)));
      else if (kind == 1) qAddr.push_back(base + AW'((N + $urandom_range(0, 5)) * LINE));
      else                qAddr.push_back(base + AW'(line * LINE));
      qData.push_back(randLine());
   endtask

   task automatic buildRandom(input logic [AW-1:0] base);
      int order[N];
      int j;
      int t;
      qAddr.delete();
      qData.delete();
      for (int i = 0; i < N; i++) order[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         j        = $urandom_range(0, i);
         t        = order[i];
         order[i] = order[j];
         order[j] = t;
      end
      if ($urandom_range(0, 3) == 0) pushBad(base, order[0]);
      for (int i = 0; i < N; i++) begin
         qAddr.push_back(base + AW'(order[i] * LINE));
         qData.push_back(randLine());
         if ($urandom_range(0, 2) == 0) pushBad(base, order[i]);
      end
   endtask

   initial begin
      logic [CW-1:0] a;
      logic [CW-1:0] b;
      logic [CW-1:0] c;
      int            pulsesBefore;
      int            waited;

      areset          = 1'b1;
      setup_start     = 1'b0;
      setup_base_addr = '0;
      rsp_in_valid    = 1'b0;
      rsp_in_addr     = '0;
      rsp_in_data     = '0;
      step(3);
      checkOutput("reset_ready", CW'(rsp_in_ready), CW'(0));
      checkOutput("reset_busy", CW'(setup_busy), CW'(0));
      checkOutput("reset_valid", CW'(setup_valid), CW'(0));
      checkOutput("reset_error", CW'(setup_error), CW'(0));
      for (int i = 0; i < N; i++) expLines[i] = '0;
      checkPayload("reset_payload");
      areset = 1'b0;
      step(2);

      a = randLine();
      b = randLine();
      c = randLine();

      $display("[TB] in-order collection with late duplicate");
      qAddr = '{64'h1000, 64'h1040};
      qData = '{a, b};
      applyStimulus(64'h1000, 1'b1, -1);

      $display("[TB] out-of-order collection with stray start");
      qAddr = '{64'h1040, 64'h1000};
      qData = '{b, a};
      applyStimulus(64'h1000, 1'b0, 1);

      $display("[TB] out-of-range response");
      qAddr = '{64'h1080, 64'h1000, 64'h1040};
      qData = '{c, a, b};
      applyStimulus(64'h1000, 1'b0, -1);

      $display("[TB] duplicate response");
      qAddr = '{64'h1000, 64'h1000, 64'h1040};
      qData = '{a, c, b};
      applyStimulus(64'h1000, 1'b0, -1);

      $display("[TB] reset mid-collection");
      pulsesBefore    = validPulses;
      setup_start     = 1'b1;
      setup_base_addr = 64'h2000;
      step();
      setup_start  = 1'b0;
      rsp_in_valid = 1'b1;
      rsp_in_addr  = 64'h2000;
      rsp_in_data  = a;
      step();
      rsp_in_valid = 1'b0;
      areset       = 1'b1;
      step(2);
      checkOutput("midreset_ready", CW'(rsp_in_ready), CW'(0));
      checkOutput("midreset_busy", CW'(setup_busy), CW'(0));
      checkOutput("midreset_error", CW'(setup_error), CW'(0));
      for (int i = 0; i < N; i++) expLines[i] = '0;
      checkPayload("midreset_payload");
      areset = 1'b0;
      step(2);
      checkOutput("midreset_no_pulse", CW'(validPulses - pulsesBefore), CW'(0));
      qAddr = '{64'h2040, 64'h2000};
      qData = '{c, b};
      applyStimulus(64'h2000, 1'b0, -1);

      $display("[TB] randomized collections");
      for (int r = 0; r < 25; r++) begin
         logic [AW-1:0] base;
         base = {$urandom, $urandom};
         buildRandom(base);
         applyStimulus(base, r[0], -1);
      end

`ifdef GLAY_SETUP_RSP_TIMEOUT_EN
      $display("[TB] watchdog with a single line");
      pulsesBefore    = validPulses;
      setup_start     = 1'b1;
      setup_base_addr = 64'h1000;
      step();
      setup_start  = 1'b0;
      rsp_in_valid = 1'b1;
      rsp_in_addr  = 64'h1000;
      rsp_in_data  = a;
      step();
      rsp_in_valid = 1'b0;
      waited       = 0;
      while (setup_valid !== 1'b1 && waited < 100) begin
         step();
         waited++;
      end
      checkOutput("timeout_window", CW'(waited >= 16 && waited <= 18), CW'(1));
      checkOutput("timeout_error", CW'(setup_error), CW'(1));
      expLines[0] = a;
      expLines[1] = '0;
      checkPayload("timeout_payload");
      step();
      checkOutput("timeout_pulse_count", CW'(validPulses - pulsesBefore), CW'(1));
`else
      pulsesBefore = validPulses;
      waited       = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
